pipe_rr_arbiter: RTL and testbench

//  Shares one registered pipe stage between N valid/ready requesters.

---
 rtl/cbb_pkg.sv | 9 +
 rtl/pipe_rr_arbiter_rr_pick.sv | 34 +++
 rtl/pipe_rr_arbiter.sv | 133 +++++++++++++
 tb/tb_pipe_rr_arbiter.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cbb_pkg.sv
// Shared helpers for the common building blocks.
package cbb_pkg;

  // Width of an index into n items; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pipe_rr_arbiter_rr_pick.sv
// Rotating-priority one-hot picker: the first request at or above ptr wins,
// otherwise the scan wraps around to the lowest index.
module rr_pick
  import cbb_pkg::*;
#(
  parameter int N = 4,
  localparam int PW = idx_w(N)
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt
);

  logic found;

  // Two-pass scan: upper segment [ptr..N-1] first, then the wrapped segment [0..ptr-1].
  always_comb begin
    gnt   = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && (i >= int'(ptr))) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!found && req[i] && (i < int'(ptr))) begin
        gnt[i] = 1'b1;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pipe_rr_arbiter.sv
// Burst-granular round-robin arbiter feeding one registered pipe stage.
// The captured beat carries its source index; flush kills the stage output
// and breaks any burst lock.
module pipe_rr_arbiter
  import cbb_pkg::*;
#(
  parameter int N     = 4,
  parameter int WIDTH = 16,
  localparam int IDW  = idx_w(N)
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 flush,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic [N-1:0]         in_last,
  input  logic [N*WIDTH-1:0]   in_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic [IDW-1:0]       out_id,
  output logic                 out_last
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [IDW-1:0]   id_q, id_d;
  logic             last_q, last_d;
  logic [IDW-1:0]   ptr_q, ptr_d;
  logic             lock_q, lock_d;
  logic [IDW-1:0]   owner_q, owner_d;

  logic             stageRdy;
  logic [N-1:0]     pickGnt;
  logic [N-1:0]     grant;
  logic [N-1:0]     accept;
  logic             accAny;
  logic [IDW-1:0]   accIdx;
  logic [WIDTH-1:0] accData;
  logic             accLast;

  assign stageRdy  = ~valid_q | out_ready | flush;
  assign out_valid = valid_q & ~flush;
  assign out_data  = data_q;
  assign out_id    = id_q;
  assign out_last  = last_q;

  rr_pick #(.N(N)) uPick (
    .req (in_valid),
    .ptr (ptr_q),
    .gnt (pickGnt)
  );

  // While a burst holds the lock only its owner may be granted, even if it idles.
  always_comb begin
    grant = '0;
    for (int i = 0; i < N; i++) begin
      if (lock_q) grant[i] = (owner_q == IDW'(i));
      else        grant[i] = pickGnt[i];
    end
  end

  // Reset gating keeps every requester stalled while the block is held in reset.
  assign in_ready = grant & {N{stageRdy & ~reset}};
  assign accept   = in_valid & in_ready;
  assign accAny   = |accept;

  // Grant is one-hot, so the accepted beat is a simple select.
  always_comb begin
    accIdx  = '0;
    accData = '0;
    accLast = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (accept[i]) begin
        accIdx  = IDW'(i);
        accData = in_data[i*WIDTH +: WIDTH];
        accLast = in_last[i];
      end
    end
  end

  // Next-state: the stage reloads whenever it can move; last beat rotates priority,
  // any other beat locks onto its source; flush always drops the lock.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    id_d    = id_q;
    last_d  = last_q;
    ptr_d   = ptr_q;
    lock_d  = lock_q;
    owner_d = owner_q;
    if (stageRdy) begin
      valid_d = accAny;
      if (accAny) begin
        data_d = accData;
        id_d   = accIdx;
        last_d = accLast;
      end
    end
    if (accAny) begin
      if (accLast) begin
        lock_d = 1'b0;
        ptr_d  = (accIdx == IDW'(N-1)) ? '0 : accIdx + IDW'(1);
      end else begin
        lock_d  = 1'b1;
        owner_d = accIdx;
      end
    end
    if (flush) lock_d = 1'b0;
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      id_q    <= '0;
      last_q  <= 1'b0;
      ptr_q   <= '0;
      lock_q  <= 1'b0;
      owner_q <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      id_q    <= id_d;
      last_q  <= last_d;
      ptr_q   <= ptr_d;
      lock_q  <= lock_d;
      owner_q <= owner_d;
    end
  end

endmodule

// File: tb/tb_pipe_rr_arbiter.sv
// Self-checking bench for pipe_rr_arbiter: reference model plus scoreboard,
// table-driven vectors and hand-written corner sequences.
module tb_pipe_rr_arbiter;

  localparam int N     = 4;
  localparam int WIDTH = 16;
  localparam int IDW   = 2;

  logic               clock = 1'b0;
  logic               reset;
  logic               flush;
  logic [N-1:0]       in_valid;
  logic [N-1:0]       in_ready;
  logic [N-1:0]       in_last;
  logic [N*WIDTH-1:0] in_data;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;
  logic [IDW-1:0]     out_id;
  logic               out_last;

  typedef struct {
    logic [N-1:0]   valid;
    logic [N-1:0]   last;
    logic           ordy;
    logic           fl;
    logic [N-1:0]   expRdy;
    logic           expOV;
    logic [IDW-1:0] expId;
  } vec_t;

  typedef struct {
    logic [IDW-1:0]   id;
    logic [WIDTH-1:0] data;
    logic             last;
  } beat_t;

  beat_t sb[$];
  vec_t  t2[6];
  vec_t  t3[6];
  int    checks = 0;
  int    errors = 0;
  int    beatCnt[N];
  logic  mValid;
  int    mPtr;
  logic  mLock;
  int    mOwner;
  logic [N-1:0] accSeen;
  logic [N-1:0] curV;
  logic [N-1:0] curL;

  pipe_rr_arbiter #(.N(N), .WIDTH(WIDTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_last   (in_last),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_id    (out_id),
    .out_last  (out_last)
  );

  always #5 clock = ~clock;

  // Hard stop in case the run never reaches its summary.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [WIDTH-1:0] dataOf(input int i);
    return {4'(i), 12'(beatCnt[i])};
  endfunction

  function automatic logic [N-1:0] modelGrant(input logic [N-1:0] v);
    logic [N-1:0] g;
    g = '0;
    if (mLock) begin
      g[mOwner] = 1'b1;
      return g;
    end
    for (int k = 0; k < N; k++) begin
      int j;
      j = (mPtr + k) % N;
      if (v[j]) begin
        g[j] = 1'b1;
        return g;
      end
    end
    return g;
  endfunction

  task automatic modelReset();
    mValid = 1'b0;
    mPtr   = 0;
    mLock  = 1'b0;
    mOwner = 0;
    sb.delete();
  endtask

  // One clock cycle: drive inputs, compare against the model, advance the model.
  task automatic applyStimulus(input logic [N-1:0] v, input logic [N-1:0] l, input logic ordy,
                               input logic fl, input bit useExp, input logic [N-1:0] expRdy,
                               input logic expOV, input logic [IDW-1:0] expId);
    logic         stageRdy;
    logic [N-1:0] expIn;
    logic [N-1:0] acc;
    beat_t        b;
    @(negedge clock);
    in_valid  = v;
    in_last   = l;
    out_ready = ordy;
    flush     = fl;
    for (int i = 0; i < N; i++) in_data[i*WIDTH +: WIDTH] = dataOf(i);
    #1;
    stageRdy = !mValid || ordy || fl;
    expIn    = stageRdy ? modelGrant(v) : '0;
    checkOutput("in_ready", in_ready, expIn);
    checkOutput("out_valid", out_valid, mValid && !fl);
    if (useExp) begin
      checkOutput("tbl_in_ready", in_ready, expRdy);
      checkOutput("tbl_out_valid", out_valid, expOV);
      if (expOV) checkOutput("tbl_out_id", out_id, expId);
    end
    if (mValid) begin
      if (sb.size() == 0) begin
        checkOutput("scoreboard_empty", 1, 0);
      end else if (fl) begin
        void'(sb.pop_front());
      end else begin
        b = sb[0];
        checkOutput("sb_out_id", out_id, b.id);
        checkOutput("sb_out_data", out_data, b.data);
        checkOutput("sb_out_last", out_last, b.last);
        if (ordy) void'(sb.pop_front());
      end
    end
    acc = v & expIn;
    if (stageRdy) mValid = |acc;
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        b.id   = IDW'(i);
        b.data = dataOf(i);
        b.last = l[i];
        sb.push_back(b);
        beatCnt[i]++;
        if (l[i]) begin
          mLock = 1'b0;
          mPtr  = (i == N-1) ? 0 : i + 1;
        end else begin
          mLock  = 1'b1;
          mOwner = i;
        end
      end
    end
    if (fl) mLock = 1'b0;
    accSeen = acc;
    @(posedge clock);
  endtask

  task automatic cyc(input logic [N-1:0] v, input logic [N-1:0] l, input logic ordy, input logic fl);
    applyStimulus(v, l, ordy, fl, 1'b0, '0, 1'b0, '0);
  endtask

  task automatic doReset();
    @(negedge clock);
    reset     = 1'b1;
    in_valid  = '0;
    in_last   = '0;
    flush     = 1'b0;
    out_ready = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    modelReset();
    #1;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_out_id", out_id, 0);
    checkOutput("rst_out_last", out_last, 0);
  endtask

  initial begin
    // Vectors: {valid, last, out_ready, flush, exp in_ready, exp out_valid, exp out_id}
    t2[0] = '{4'b1111, 4'b1111, 1'b1, 1'b0, 4'b0001, 1'b0, 2'd0};
    t2[1] = '{4'b1111, 4'b1111, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd0};
    t2[2] = '{4'b1111, 4'b1111, 1'b1, 1'b0, 4'b0100, 1'b1, 2'd1};
    t2[3] = '{4'b1111, 4'b1111, 1'b1, 1'b0, 4'b1000, 1'b1, 2'd2};
    t2[4] = '{4'b1111, 4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1, 2'd3};
    t2[5] = '{4'b1111, 4'b1111, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd0};
    t3[0] = '{4'b0110, 4'b0100, 1'b1, 1'b0, 4'b0010, 1'b0, 2'd0};
    t3[1] = '{4'b0110, 4'b0100, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd1};
    t3[2] = '{4'b0110, 4'b0110, 1'b1, 1'b0, 4'b0010, 1'b1, 2'd1};
    t3[3] = '{4'b0110, 4'b0110, 1'b1, 1'b0, 4'b0100, 1'b1, 2'd1};
    t3[4] = '{4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 2'd2};
    t3[5] = '{4'b0000, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 2'd0};

    reset     = 1'b1;
    flush     = 1'b0;
    in_valid  = '0;
    in_last   = '0;
    in_data   = '0;
    out_ready = 1'b1;
    for (int i = 0; i < N; i++) beatCnt[i] = 0;
    modelReset();
    doReset();

    // Reset asserted in the middle of traffic.
    cyc(4'b1111, 4'b1111, 1'b1, 1'b0);
    cyc(4'b1111, 4'b0000, 1'b1, 1'b0);
    cyc(4'b1111, 4'b0000, 1'b1, 1'b0);
    @(negedge clock);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("midrst_out_valid", out_valid, 0);
    checkOutput("midrst_in_ready", in_ready, 0);
    @(posedge clock);
    @(negedge clock);
    in_valid = '0;
    reset    = 1'b0;
    modelReset();
    #1;
    checkOutput("midrst_release_out_valid", out_valid, 0);

    // All requesters streaming single-beat bursts: ids rotate 0,1,2,3,0.
    for (int k = 0; k < 6; k++)
      applyStimulus(t2[k].valid, t2[k].last, t2[k].ordy, t2[k].fl, 1'b1,
                    t2[k].expRdy, t2[k].expOV, t2[k].expId);

    // Three-beat burst from req1 keeps req2 waiting.
    doReset();
    for (int k = 0; k < 6; k++)
      applyStimulus(t3[k].valid, t3[k].last, t3[k].ordy, t3[k].fl, 1'b1,
                    t3[k].expRdy, t3[k].expOV, t3[k].expId);

    // Five cycles of backpressure, then the next beat follows without a gap.
    doReset();
    cyc(4'b0001, 4'b0001, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++)
      applyStimulus(4'b0011, 4'b0011, 1'b0, 1'b0, 1'b1, 4'b0000, 1'b1, 2'd0);
    applyStimulus(4'b0011, 4'b0011, 1'b1, 1'b0, 1'b1, 4'b0010, 1'b1, 2'd0);
    applyStimulus(4'b0001, 4'b0001, 1'b1, 1'b0, 1'b1, 4'b0001, 1'b1, 2'd1);
    cyc(4'b0000, 4'b0000, 1'b1, 1'b0);
    cyc(4'b0000, 4'b0000, 1'b1, 1'b0);

    // Flush on beat 2 of a req3 burst releases the lock to the round-robin winner.
    doReset();
    applyStimulus(4'b1000, 4'b0000, 1'b1, 1'b0, 1'b1, 4'b1000, 1'b0, 2'd0);
    applyStimulus(4'b1001, 4'b0000, 1'b1, 1'b1, 1'b1, 4'b1000, 1'b0, 2'd0);
    applyStimulus(4'b1001, 4'b0000, 1'b1, 1'b0, 1'b1, 4'b0001, 1'b1, 2'd3);
    applyStimulus(4'b1001, 4'b1001, 1'b1, 1'b0, 1'b1, 4'b0001, 1'b1, 2'd0);
    cyc(4'b0000, 4'b0000, 1'b1, 1'b0);
    cyc(4'b0000, 4'b0000, 1'b1, 1'b0);

    // Pointer at 2 with only req0 requesting: wrap-around, then pointer moves to 1.
    doReset();
    cyc(4'b0010, 4'b0010, 1'b1, 1'b0);
    applyStimulus(4'b0001, 4'b0001, 1'b1, 1'b0, 1'b1, 4'b0001, 1'b1, 2'd1);
    applyStimulus(4'b0101, 4'b0101, 1'b1, 1'b0, 1'b1, 4'b0100, 1'b1, 2'd0);
    cyc(4'b0000, 4'b0000, 1'b1, 1'b0);
    cyc(4'b0000, 4'b0000, 1'b1, 1'b0);

    // Random traffic obeying the hold-until-accepted rule, with sporadic flush and stalls.
    doReset();
    curV = '0;
    curL = '0;
    accSeen = '0;
    for (int c = 0; c < 300; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!curV[i] || accSeen[i]) begin
          curV[i] = 1'($urandom_range(0, 1));
          curL[i] = ($urandom_range(0, 2) == 0);
        end
      end
      cyc(curV, curL, 1'($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0));
    end
    cyc(4'b0000, 4'b0000, 1'b1, 1'b0);
    cyc(4'b0000, 4'b0000, 1'b1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
